// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller: per-register in-flight scoreboard, RAW stall on DE, branch squash sequencing.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REGWORDS   = 32,
  parameter int REGNOBITS  = 5,
  parameter int BR_PENALTY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_wregno,
  input  logic                 wb_valid,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic                 agex_br_taken,
  output logic                 stall_fe,
  output logic                 stall_de,
  output logic                 bubble_agex,
  output logic                 flush_de,
  output logic                 de_issue,
  output logic [REGWORDS-1:0]  busy_bits,
  output logic                 err_sticky,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_cycles
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(BR_PENALTY - 1);

  state_t              state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [1:0]          cnt_q [REGWORDS];
  logic [1:0]          cnt_d [REGWORDS];
  logic                err_q, err_d;
  logic [REGWORDS-1:0] busy;
  logic                hazard, in_flush, inc_en, dec_en;

  always_comb begin
    for (int r = 0; r < REGWORDS; r++) busy[r] = (cnt_q[r] != 2'd0);
  end

  assign busy_bits  = busy;
  assign err_sticky = err_q;

  // While reset is asserted the outputs behave as if the scoreboard were empty and the FSM idle.
  assign hazard = ~reset & de_valid &
                  ((de_rs1_used & (de_rs1 != '0) & busy[de_rs1]) |
                   (de_rs2_used & (de_rs2 != '0) & busy[de_rs2]));
  assign in_flush    = ~reset & (state_q == FLUSH);
  assign flush_de    = agex_br_taken | in_flush;
  assign stall_fe    = hazard & ~flush_de;
  assign stall_de    = hazard & ~flush_de;
  assign bubble_agex = hazard | flush_de;
  assign de_issue    = de_valid & ~hazard & ~flush_de;

  assign inc_en = de_issue & de_wr_reg & (de_wregno != '0);
  assign dec_en = wb_valid & wb_wr_reg & (wb_wregno != '0);

  // fcnt holds the flush cycles still owed after the current one; BR_PENALTY=1 never enters FLUSH.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (agex_br_taken) begin
          fcnt_d  = FLUSH_LOAD;
          state_d = (BR_PENALTY > 1) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (agex_br_taken) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q <= 2'd1) begin
          state_d = IDLE;
          fcnt_d  = 2'd0;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  always_comb begin
    err_d    = err_q;
    cnt_d[0] = 2'd0;
    for (int r = 1; r < REGWORDS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_en && (de_wregno == REGNOBITS'(r)) &&
          !(dec_en && (wb_wregno == REGNOBITS'(r)))) begin
        if (cnt_q[r] == 2'd3) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec_en && (wb_wregno == REGNOBITS'(r)) &&
                   !(inc_en && (de_wregno == REGNOBITS'(r)))) begin
        if (cnt_q[r] == 2'd0) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= 2'd0;
      err_q   <= 1'b0;
      for (int r = 0; r < REGWORDS; r++) cnt_q[r] <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      for (int r = 0; r < REGWORDS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_de};
    flush_cycles_d = flush_cycles_q + {31'd0, flush_de};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
